// File: rtl/mode_switch_mux_if.sv
// Bundle of the mode selector's request inputs, per-mode output bundles and board-pin outputs.
//   master : drives buttons, enable/busy masks and per-mode bundles; observes pin outputs
//   slave  : the selector itself (mode_switch_mux)
// Per-mode buses pack mode i at [i*W +: W].
interface mode_switch_mux_if #(
  parameter int unsigned NUM_MODES = 3,
  parameter int unsigned MODE_W    = 2,
  parameter int unsigned SEG_W     = 8,
  parameter int unsigned AN_W      = 4,
  parameter int unsigned ACT_W     = 3,
  parameter int unsigned LED_W     = 16
);
  logic                       btn_next;
  logic                       btn_prev;
  logic [NUM_MODES-1:0]       mode_enable;
  logic [NUM_MODES-1:0]       mode_busy;
  logic [NUM_MODES*SEG_W-1:0] mode_seg;
  logic [NUM_MODES*AN_W-1:0]  mode_an;
  logic [NUM_MODES-1:0]       mode_buzzer;
  logic [NUM_MODES*ACT_W-1:0] mode_act;

  logic [SEG_W-1:0]           seg;
  logic [AN_W-1:0]            an;
  logic                       buzzer;
  logic [ACT_W-1:0]           act;
  logic [LED_W-1:0]           led;
  logic [MODE_W-1:0]          mode;
  logic                       mode_change;
  logic                       switch_denied;

  modport master (
    output btn_next, btn_prev, mode_enable, mode_busy,
    output mode_seg, mode_an, mode_buzzer, mode_act,
    input  seg, an, buzzer, act, led, mode, mode_change, switch_denied
  );

  modport slave (
    input  btn_next, btn_prev, mode_enable, mode_busy,
    input  mode_seg, mode_an, mode_buzzer, mode_act,
    output seg, an, buzzer, act, led, mode, mode_change, switch_denied
  );
endinterface

// File: rtl/mode_switch_mux.sv
// mode_switch_mux: active-mode selector and output multiplexer for NUM_MODES appliance apps.
//
// Steps the active mode forward/back on one-cycle button pulses, skipping disabled modes and
// refusing to leave a busy mode. The active mode's seg/an/buzzer/act bundle is registered onto
// the board pins (1-cycle latency); every accepted switch blanks the pins for BLANK_CYCLES.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   bus    mode_switch_mux_if.slave
//          in : btn_next, btn_prev, mode_enable, mode_busy, mode_seg, mode_an, mode_buzzer,
//               mode_act
//          out: seg, an, buzzer, act (registered pins), led (one-hot mode indicator in the
//               top NUM_MODES bits), mode, mode_change, switch_denied (one-cycle pulses)
//
// Configuration macro:
//   MODE_BEEP_EN  buzzer held high for every blanking cycle and for the cycle switch_denied
//                 pulses. Undefined: buzzer is 0 while blanked and denials are silent.
module mode_switch_mux #(
  parameter int unsigned NUM_MODES    = 3,
  parameter int unsigned MODE_W       = 2,
  parameter int unsigned SEG_W        = 8,
  parameter int unsigned AN_W         = 4,
  parameter int unsigned ACT_W        = 3,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input logic              clk,
  input logic              reset,
  mode_switch_mux_if.slave bus
);

  localparam int unsigned CntW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(BLANK_CYCLES - 1);
  localparam logic [MODE_W:0] NumModesW = (MODE_W + 1)'(NUM_MODES);

  typedef enum logic [0:0] {
    StActive,
    StBlank
  } state_e;

  // Nearest enabled mode other than cur, walking forward or backward with wrap-around.
  // Returns {found, index}; found=0 when cur is the only enabled mode (or none are).
  function automatic logic [MODE_W:0] seek_enabled(input logic [MODE_W-1:0]    cur,
                                                   input logic [NUM_MODES-1:0] en,
                                                   input logic                 fwd);
    logic [MODE_W:0]   res;
    logic [MODE_W:0]   sum;
    logic [MODE_W-1:0] idx;
    res = '0;
    // Walk from the farthest offset inwards so the nearest hit is the one that sticks.
    for (int off = int'(NUM_MODES) - 1; off >= 1; off--) begin
      // Backward step is done as +(N-off) so both directions stay in [0, 2N).
      if (fwd) begin
        sum = {1'b0, cur} + (MODE_W + 1)'(off);
      end else begin
        sum = {1'b0, cur} + NumModesW - (MODE_W + 1)'(off);
      end
      if (sum >= NumModesW) begin
        sum = sum - NumModesW;
      end
      idx = sum[MODE_W-1:0];
      if (en[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   blank_cnt_q, blank_cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              mode_change_q, mode_change_d;
  logic              switch_denied_q, switch_denied_d;
  logic [SEG_W-1:0]  seg_q, seg_d;
  logic [AN_W-1:0]   an_q, an_d;
  logic              buzzer_q, buzzer_d;
  logic [ACT_W-1:0]  act_q, act_d;
  logic [LED_W-1:0]  led_q, led_d;

  logic              any_en;
  logic              cur_en;
  logic              cur_busy;
  logic [MODE_W:0]   fwd_seek;
  logic [MODE_W:0]   bwd_seek;
  logic [MODE_W:0]   req_seek;
  logic              one_btn;
  logic              blank_out;

  assign any_en   = |bus.mode_enable;
  assign cur_en   = bus.mode_enable[mode_q];
  assign cur_busy = bus.mode_busy[mode_q];
  assign fwd_seek = seek_enabled(mode_q, bus.mode_enable, 1'b1);
  assign bwd_seek = seek_enabled(mode_q, bus.mode_enable, 1'b0);
  assign one_btn  = bus.btn_next ^ bus.btn_prev;
  assign req_seek = bus.btn_next ? fwd_seek : bwd_seek;

  // Mode sequencing.
  always_comb begin
    state_d         = state_q;
    blank_cnt_d     = blank_cnt_q;
    mode_d          = mode_q;
    mode_change_d   = 1'b0;
    switch_denied_d = 1'b0;

    unique case (state_q)
      StActive: begin
        // With nothing enabled the current mode is simply held.
        if (any_en) begin
          if (!cur_en) begin
            // Current mode was disabled under us: forced forward move, busy is ignored.
            // fwd_seek always hits here because another mode must be enabled.
            if (fwd_seek[MODE_W]) begin
              mode_d        = fwd_seek[MODE_W-1:0];
              mode_change_d = 1'b1;
              state_d       = StBlank;
              blank_cnt_d   = CntLoad;
            end
          end else if (one_btn) begin
            if (cur_busy || !req_seek[MODE_W]) begin
              switch_denied_d = 1'b1;
            end else begin
              mode_d        = req_seek[MODE_W-1:0];
              mode_change_d = 1'b1;
              state_d       = StBlank;
              blank_cnt_d   = CntLoad;
            end
          end
        end
      end
      StBlank: begin
        // Buttons are ignored here; the counter runs down to 0 then returns to active.
        if (blank_cnt_q == '0) begin
          state_d = StActive;
        end else begin
          blank_cnt_d = blank_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StActive;
      end
    endcase
  end

  // Pin outputs are registered: they reflect the state being entered, so the cycle right
  // after an accept is already blanked and the first unblanked cycle shows the new mode.
  assign blank_out = (state_d == StBlank) || !any_en;

  always_comb begin
    seg_d = '1;
    an_d  = '1;
    act_d = '0;
    led_d = '0;
    if (!blank_out) begin
      seg_d = bus.mode_seg[mode_q*SEG_W +: SEG_W];
      an_d  = bus.mode_an[mode_q*AN_W +: AN_W];
      act_d = bus.mode_act[mode_q*ACT_W +: ACT_W];
    end
`ifdef MODE_BEEP_EN
    // Switch chirp across the whole blanking window, plus a one-cycle beep on refusal.
    buzzer_d = (state_d == StBlank) || switch_denied_d ||
               (!blank_out && bus.mode_buzzer[mode_q]);
`else
    buzzer_d = !blank_out && bus.mode_buzzer[mode_q];
`endif
    // LED tracks the mode being entered so it updates at the start of blanking.
    for (int i = 0; i < int'(NUM_MODES); i++) begin
      led_d[LED_W-1-i] = any_en && (mode_d == MODE_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StActive;
      blank_cnt_q     <= '0;
      mode_q          <= '0;
      mode_change_q   <= 1'b0;
      switch_denied_q <= 1'b0;
      seg_q           <= '1;
      an_q            <= '1;
      buzzer_q        <= 1'b0;
      act_q           <= '0;
      led_q           <= '0;
    end else begin
      state_q         <= state_d;
      blank_cnt_q     <= blank_cnt_d;
      mode_q          <= mode_d;
      mode_change_q   <= mode_change_d;
      switch_denied_q <= switch_denied_d;
      seg_q           <= seg_d;
      an_q            <= an_d;
      buzzer_q        <= buzzer_d;
      act_q           <= act_d;
      led_q           <= led_d;
    end
  end

  assign bus.seg           = seg_q;
  assign bus.an            = an_q;
  assign bus.buzzer        = buzzer_q;
  assign bus.act           = act_q;
  assign bus.led           = led_q;
  assign bus.mode          = mode_q;
  assign bus.mode_change   = mode_change_q;
  assign bus.switch_denied = switch_denied_q;

endmodule

// File: tb/tb_mode_switch_mux.sv
// Self-checking bench for mode_switch_mux: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model of the selector.
module tb_mode_switch_mux;

  localparam int NM    = 3;
  localparam int MW    = 2;
  localparam int SW    = 8;
  localparam int AW    = 4;
  localparam int CW    = 3;
  localparam int LW    = 16;
  localparam int BLANK = 4;
`ifdef MODE_BEEP_EN
  localparam bit Beep = 1'b1;
`else
  localparam bit Beep = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  mode_switch_mux_if #(
    .NUM_MODES(NM), .MODE_W(MW), .SEG_W(SW), .AN_W(AW), .ACT_W(CW), .LED_W(LW)
  ) bus ();

  mode_switch_mux #(
    .NUM_MODES(NM), .MODE_W(MW), .SEG_W(SW), .AN_W(AW), .ACT_W(CW), .LED_W(LW),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: current mode and number of blanking cycles still to show
  // (including the current one); 0 means the selector is active.
  int              m_mode;
  int              m_blank;
  logic [SW-1:0]   e_seg;
  logic [AW-1:0]   e_an;
  logic            e_buz;
  logic [CW-1:0]   e_act;
  logic [LW-1:0]   e_led;
  logic            e_change;
  logic            e_denied;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit en_bit(input int idx);
    logic [NM-1:0] v;
    v = bus.mode_enable >> idx;
    return v[0];
  endfunction

  function automatic bit busy_bit(input int idx);
    logic [NM-1:0] v;
    v = bus.mode_busy >> idx;
    return v[0];
  endfunction

  // Nearest other enabled mode in the given direction, or -1 if there is none.
  function automatic int find_target(input int cur, input bit fwd);
    for (int d = 1; d < NM; d++) begin
      int idx;
      idx = fwd ? (cur + d) % NM : (cur + NM - d) % NM;
      if (en_bit(idx)) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit any;
    bit acc;
    bit dny;
    bit blank;
    int tgt;
    int old;
    logic [NM*SW-1:0] sv;
    logic [NM*AW-1:0] av;
    logic [NM*CW-1:0] cv;
    logic [NM-1:0]    bv;
    if (reset) begin
      m_mode = 0; m_blank = 0;
      e_seg = '1; e_an = '1; e_buz = 1'b0; e_act = '0; e_led = '0;
      e_change = 1'b0; e_denied = 1'b0;
      return;
    end
    any = (bus.mode_enable != '0);
    acc = 1'b0;
    dny = 1'b0;
    tgt = m_mode;
    old = m_mode;
    if (m_blank > 0) begin
      m_blank = m_blank - 1;
    end else if (any) begin
      if (!en_bit(m_mode)) begin
        tgt = find_target(m_mode, 1'b1);
        acc = 1'b1;
      end else if (bus.btn_next != bus.btn_prev) begin
        tgt = find_target(m_mode, bus.btn_next);
        if (busy_bit(m_mode) || tgt < 0) dny = 1'b1;
        else acc = 1'b1;
      end
    end
    if (acc) begin
      m_mode  = tgt;
      m_blank = BLANK;
    end
    blank = (m_blank > 0) || !any;
    sv = bus.mode_seg >> (old * SW);
    av = bus.mode_an >> (old * AW);
    cv = bus.mode_act >> (old * CW);
    bv = bus.mode_buzzer >> old;
    e_seg = blank ? '1 : sv[SW-1:0];
    e_an  = blank ? '1 : av[AW-1:0];
    e_act = blank ? '0 : cv[CW-1:0];
    if (m_blank > 0)    e_buz = Beep;
    else if (!any)      e_buz = 1'b0;
    else if (dny)       e_buz = Beep | bv[0];
    else                e_buz = bv[0];
    e_led = '0;
    if (any) e_led[LW-1-m_mode] = 1'b1;
    e_change = acc;
    e_denied = dny;
  endtask

  task automatic cyc();
    bus.mode_seg    = (NM*SW)'({$urandom, $urandom});
    bus.mode_an     = (NM*AW)'($urandom);
    bus.mode_act    = (NM*CW)'($urandom);
    bus.mode_buzzer = NM'($urandom);
    @(posedge clk);
    model_step();
    #1;
    chk("seg", 32'(bus.seg), 32'(e_seg));
    chk("an", 32'(bus.an), 32'(e_an));
    chk("buzzer", 32'(bus.buzzer), 32'(e_buz));
    chk("act", 32'(bus.act), 32'(e_act));
    chk("led", 32'(bus.led), 32'(e_led));
    chk("mode", 32'(bus.mode), 32'(m_mode));
    chk("mode_change", 32'(bus.mode_change), 32'(e_change));
    chk("switch_denied", 32'(bus.switch_denied), 32'(e_denied));
  endtask

  task automatic press(input bit nxt, input bit prv);
    bus.btn_next = nxt;
    bus.btn_prev = prv;
    cyc();
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_mode   = 0;
    m_blank  = 0;
    reset    = 1'b1;
    bus.btn_next    = 1'b0;
    bus.btn_prev    = 1'b0;
    bus.mode_enable = 3'b111;
    bus.mode_busy   = 3'b000;

    // 1: reset state, then three forward steps 0->1->2->0 with blanking each time.
    do_reset();
    chk("t1_reset_seg", 32'(bus.seg), 32'hFF);
    chk("t1_reset_led", 32'(bus.led), 32'h0);
    idle(2);
    chk("t1_led_mode0", 32'(bus.led), 32'h8000);
    for (int k = 0; k < 3; k++) begin
      press(1'b1, 1'b0);
      chk("t1_step_mode", 32'(bus.mode), 32'((k + 1) % 3));
      chk("t1_step_pulse", 32'(bus.mode_change), 32'h1);
      chk("t1_blank_seg", 32'(bus.seg), 32'hFF);
      chk("t1_blank_an", 32'(bus.an), 32'hF);
      idle(3);
      chk("t1_blank_last", 32'(bus.seg), 32'hFF);
      idle(2);
    end

    // 2: mode 1 disabled; next goes 0->2, prev wraps back to 0.
    bus.mode_enable = 3'b101;
    press(1'b1, 1'b0);
    chk("t2_next_skip", 32'(bus.mode), 32'h2);
    idle(BLANK + 1);
    press(1'b0, 1'b1);
    chk("t2_prev_wrap", 32'(bus.mode), 32'h0);
    idle(BLANK + 1);

    // 3: busy mode refuses to leave, no blanking.
    bus.mode_enable = 3'b111;
    bus.mode_busy   = 3'b001;
    press(1'b1, 1'b0);
    chk("t3_denied", 32'(bus.switch_denied), 32'h1);
    chk("t3_mode_held", 32'(bus.mode), 32'h0);
    cyc();
    chk("t3_denied_once", 32'(bus.switch_denied), 32'h0);
    bus.mode_busy = 3'b000;

    // 4: both buttons ignored; a press during blanking is ignored.
    press(1'b1, 1'b1);
    chk("t4_both_mode", 32'(bus.mode), 32'h0);
    chk("t4_both_pulse", 32'(bus.mode_change | bus.switch_denied), 32'h0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    chk("t4_blank_ignored", 32'(bus.mode), 32'h1);
    idle(BLANK + 1);

    // 5: forced move out of a disabled busy mode, then reset at blanking cycle 2.
    bus.mode_busy   = 3'b010;
    bus.mode_enable = 3'b101;
    cyc();
    chk("t5_forced", 32'(bus.mode), 32'h2);
    chk("t6_beep_first", 32'(bus.buzzer), 32'(Beep));
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_reset_mode", 32'(bus.mode), 32'h0);
    chk("t5_reset_seg", 32'(bus.seg), 32'hFF);
    bus.mode_busy = 3'b000;
    idle(BLANK + 2);

    // 6: buzzer over a full blanking window; also reset with mode 0 disabled.
    bus.mode_enable = 3'b111;
    press(1'b0, 1'b1);
    for (int i = 0; i < BLANK - 1; i++) begin
      chk("t6_beep", 32'(bus.buzzer), 32'(Beep));
      cyc();
    end
    bus.mode_enable = 3'b110;
    do_reset();
    cyc();
    chk("t6_forced_after_reset", 32'(bus.mode), 32'h1);
    idle(BLANK + 1);

    // 7: nothing enabled -> held, blanked, led dark.
    bus.mode_enable = 3'b000;
    idle(3);
    chk("t7_led_off", 32'(bus.led), 32'h0);
    bus.mode_enable = 3'b111;
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 9);
      bus.btn_next = (r == 0) || (r == 2);
      bus.btn_prev = (r == 1) || (r == 2);
      if ($urandom_range(0, 19) == 0) bus.mode_enable = NM'($urandom);
      if ($urandom_range(0, 9) == 0)  bus.mode_busy = NM'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_prev = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
